residual_stream: RTL and testbench
==================================

Name: residual_stream

Overview:
- Parametrised successor to the 8-lane residual stage in the fractional motion estimation datapath.
- Takes NUM_LANES original and best-candidate samples per beat and produces signed residuals (original − candidate) for the transform stage.
- Adds valid/ready flow control with backpressure, a row counter that marks the last row of each BLOCK_ROWS-row block, and an optional per-block SAD.

Parameters:
- DATAWIDTH, 8, unsigned sample width; residual is DATAWIDTH+1 bits, two's complement.
- NUM_LANES, 8, samples per beat (≥1).
- BLOCK_ROWS, 8, beats per block (≥2).
- SAD_WIDTH, 14, SAD accumulator width; must hold NUM_LANES*BLOCK_ROWS*(2^DATAWIDTH−1).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of pipeline and row counter.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- original  in  NUM_LANES*DATAWIDTH  lane k at bits [k*DATAWIDTH +: DATAWIDTH].
- best_candidate  in  NUM_LANES*DATAWIDTH  same packing.
- out_valid  out  1  residual beat valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_residual  out  NUM_LANES*(DATAWIDTH+1)  lane k at [k*(DATAWIDTH+1) +: DATAWIDTH+1], signed.
- out_last  out  1  beat is row BLOCK_ROWS−1 of its block.
- out_sad  out  SAD_WIDTH  block SAD; meaningful only when out_valid && out_last (macro only).

Behaviour:
- Reset (reset low, async): s1_valid=0, s2_valid=0, row_cnt=0, all data registers=0, out_valid=0, out_last=0, out_residual=0, out_sad=0. Releases synchronously.
- Pipeline:
  - S1 registers the raw inputs and a last tag.
  - S2 registers the residuals and last.
  - Latency: 2 cycles from input handshake to out_valid with no stall.
- Advance rules:
  - s2_free = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free (combinational from out_ready).
  - Full throughput of 1 beat/cycle when out_ready is held high.
- Data stability: S1 and S2 hold contents while stalled. out_residual and out_last are stable while out_valid && !out_ready.
- Arithmetic: residual_k = {1'b0,orig_k} − {1'b0,cand_k}, computed in DATAWIDTH+1 bits. Range −(2^DATAWIDTH−1)..+(2^DATAWIDTH−1); no saturation is needed.
- Row counter:
  - Increments on each accepted input beat; wraps BLOCK_ROWS−1 → 0.
  - The S1 last tag is (row_cnt==BLOCK_ROWS−1) at acceptance.
- Flush:
  - Clears s1_valid, s2_valid and row_cnt next cycle; data registers are don't-care.
  - Overrides a simultaneous input handshake (beat dropped, in_ready still shown).
  - A partially delivered block is discarded.
- Simultaneous events: a beat may enter S1 in the same cycle S1 moves to S2 and S2 drains. No bubble is inserted.
- Reset mid-block: all state is cleared. The next accepted beat is row 0.

Optional Feature:
- Macro RESIDUAL_SAD_EN.
- Defined:
  - On each S1→S2 transfer, beat_sum = Σ|residual_k|.
  - The accumulator loads beat_sum if the transferring beat is row 0, else adds it.
  - out_sad shows the accumulator, so it is inclusive of the S2 beat; it is valid with the out_last beat.
  - Flush and reset clear it.
- Undefined: no accumulator or absolute-value logic; out_sad is tied to 0.

Test Plan:
- Reset then stream 8 beats, all lanes orig=200, cand=50, out_ready=1 → first out_valid 2 cycles after the first accept; every lane = +150 (9'h096); out_last only on beat 8.
- Lanes orig=0, cand=255 and orig=255, cand=0 → residuals −255 (9'h101) and +255 (9'h0FF).
- out_ready=0 for 5 cycles mid-stream → in_ready drops after S1 and S2 fill; out_residual unchanged through the stall; no beat lost or duplicated (checked by sequence tags in lane 0).
- flush asserted after 3 beats, then 8 new beats → no stale output appears; out_last on the 8th new beat.
- reset pulsed low for 1 cycle while out_valid=1 → out_valid=0 immediately (async); the next block counts from row 0.
- RESIDUAL_SAD_EN defined, 8 beats, each lane |orig−cand|=10 → out_sad=640 on the out_last beat. Second block with diff 1 → out_sad=64, with no carry-over.

Source files
------------

// File: rtl/residual_stream.sv
// Two-stage valid/ready residual pipeline (original - candidate) with block row tagging.
// Optional per-block SAD accumulator enabled by defining RESIDUAL_SAD_EN.
module residual_stream #(
  parameter int DATAWIDTH  = 8,
  parameter int NUM_LANES  = 8,
  parameter int BLOCK_ROWS = 8,
  parameter int SAD_WIDTH  = 14
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NUM_LANES*DATAWIDTH-1:0]       original,
  input  logic [NUM_LANES*DATAWIDTH-1:0]       best_candidate,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [NUM_LANES*(DATAWIDTH+1)-1:0]   out_residual,
  output logic                                 out_last,
  output logic [SAD_WIDTH-1:0]                 out_sad
);

  localparam int RW = DATAWIDTH + 1;
  localparam int CW = (BLOCK_ROWS > 1) ? $clog2(BLOCK_ROWS) : 1;
  localparam logic [CW-1:0] LAST_ROW = CW'(BLOCK_ROWS - 1);

  logic                          s1_valid;
  logic [NUM_LANES*DATAWIDTH-1:0] s1_orig;
  logic [NUM_LANES*DATAWIDTH-1:0] s1_cand;
  logic                          s1_last;
  logic                          s2_valid;
  logic [CW-1:0]                 row_cnt;
  logic                          s2_free;
  logic                          s1_adv;
  logic                          accept;
  logic [NUM_LANES*RW-1:0]       residual;

  assign s2_free   = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_free;
  assign in_ready  = !s1_valid || s2_free;
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = s2_valid;

  // Zero-extend both samples so the subtraction yields a signed DATAWIDTH+1 result.
  always_comb begin
    residual = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      residual[k*RW +: RW] = {1'b0, s1_orig[k*DATAWIDTH +: DATAWIDTH]}
                           - {1'b0, s1_cand[k*DATAWIDTH +: DATAWIDTH]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_cnt <= '0;
    end else if (flush) begin
      row_cnt <= '0;
    end else if (accept) begin
      row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
    end
  end

  // A new beat may load in the same cycle the held one moves on to S2.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_orig  <= '0;
      s1_cand  <= '0;
      s1_last  <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_orig  <= original;
      s1_cand  <= best_candidate;
      s1_last  <= (row_cnt == LAST_ROW);
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_valid     <= 1'b0;
      out_residual <= '0;
      out_last     <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s1_adv) begin
      s2_valid     <= 1'b1;
      out_residual <= residual;
      out_last     <= s1_last;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

`ifdef RESIDUAL_SAD_EN
  logic                 s1_first;
  logic [SAD_WIDTH-1:0] beat_sum;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_first <= 1'b0;
    end else if (accept) begin
      s1_first <= (row_cnt == '0);
    end
  end

  // Residual magnitude never exceeds 2^DATAWIDTH-1, so the low bits of the negation suffice.
  always_comb begin
    logic [RW-1:0] r;
    logic [RW-1:0] mag;
    beat_sum = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      r        = residual[k*RW +: RW];
      mag      = r[RW-1] ? (~r + 1'b1) : r;
      beat_sum = beat_sum + SAD_WIDTH'(mag[DATAWIDTH-1:0]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_sad <= '0;
    end else if (flush) begin
      out_sad <= '0;
    end else if (s1_adv) begin
      out_sad <= s1_first ? beat_sum : out_sad + beat_sum;
    end
  end
`else
  assign out_sad = '0;
`endif

endmodule

// File: tb/tb_residual_stream.sv
// Self-checking bench for residual_stream: directed scenarios plus a randomized stream
// checked against a queue-based reference model (handles RESIDUAL_SAD_EN builds too).
module tb_residual_stream;

  localparam int DW = 8;
  localparam int NL = 8;
  localparam int BR = 8;
  localparam int SW = 14;
  localparam int RW = DW + 1;

  logic               clock = 1'b0;
  logic               reset;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [NL*DW-1:0]   original;
  logic [NL*DW-1:0]   best_candidate;
  logic               out_valid;
  logic               out_ready;
  logic [NL*RW-1:0]   out_residual;
  logic               out_last;
  logic [SW-1:0]      out_sad;

  always #5 clock = ~clock;

  residual_stream #(.DATAWIDTH(DW), .NUM_LANES(NL), .BLOCK_ROWS(BR), .SAD_WIDTH(SW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .original(original), .best_candidate(best_candidate),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_residual(out_residual), .out_last(out_last), .out_sad(out_sad)
  );

  typedef struct {
    logic [NL*RW-1:0] res;
    bit               last;
    int               sad;
    bit               at_out;
  } beat_t;

  beat_t q[$];
  int    exp_row;
  int    exp_sad;
  int    tests;
  int    failures;
  int    cyc;
  int    first_acc;
  int    first_out;
  int    lasts_seen;
  int    last_sad_seen;
  bit    last_acc;
  int    tag;

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [NL*RW-1:0] model_res(input logic [NL*DW-1:0] o, input logic [NL*DW-1:0] c);
    logic [NL*RW-1:0] r;
    int d;
    r = '0;
    for (int k = 0; k < NL; k++) begin
      d = int'(o[k*DW +: DW]) - int'(c[k*DW +: DW]);
      r[k*RW +: RW] = RW'(d);
    end
    return r;
  endfunction

  function automatic int model_abs_sum(input logic [NL*DW-1:0] o, input logic [NL*DW-1:0] c);
    int s;
    int d;
    s = 0;
    for (int k = 0; k < NL; k++) begin
      d = int'(o[k*DW +: DW]) - int'(c[k*DW +: DW]);
      s += (d < 0) ? -d : d;
    end
    return s;
  endfunction

  task automatic applyStimulus(input bit v, input logic [NL*DW-1:0] o, input logic [NL*DW-1:0] c,
                               input bit rdy, input bit fl);
    in_valid       = v;
    original       = o;
    best_candidate = c;
    out_ready      = rdy;
    flush          = fl;
  endtask

  task automatic checkOutput();
    bit vis;
    vis = (q.size() > 0) && q[0].at_out;
    check("in_ready", in_ready, (q.size() < 2) || out_ready);
    check("out_valid", out_valid, vis);
    if (vis && out_valid) begin
      check("out_residual", out_residual, q[0].res);
      check("out_last", out_last, q[0].last);
`ifdef RESIDUAL_SAD_EN
      if (q[0].last) check("out_sad", out_sad, SW'(q[0].sad));
`else
      check("out_sad_tied", out_sad, 0);
`endif
      if (first_out < 0) first_out = cyc;
      if (out_last && out_ready) begin
        lasts_seen++;
        last_sad_seen = int'(out_sad);
      end
    end
  endtask

  // One clock cycle: drive, check mid-cycle, then advance the reference model at the edge.
  task automatic cycle(input bit v, input logic [NL*DW-1:0] o, input logic [NL*DW-1:0] c,
                       input bit rdy, input bit fl);
    bit    acc;
    bit    pop;
    beat_t b;
    applyStimulus(v, o, c, rdy, fl);
    #3;
    checkOutput();
    pop = (q.size() > 0) && q[0].at_out && rdy;
    acc = v && ((q.size() < 2) || pop) && !fl;
    if (acc && first_acc < 0) first_acc = cyc;
    b.res    = model_res(o, c);
    b.last   = (exp_row == BR - 1);
    b.sad    = (exp_row == 0) ? model_abs_sum(o, c) : exp_sad + model_abs_sum(o, c);
    b.at_out = 1'b0;
    @(posedge clock);
    #1;
    cyc++;
    last_acc = acc;
    if (pop) void'(q.pop_front());
    if (fl) begin
      q.delete();
      exp_row = 0;
      exp_sad = 0;
    end else begin
      if (q.size() > 0) q[0].at_out = 1'b1;
      if (acc) begin
        q.push_back(b);
        exp_sad = b.sad;
        exp_row = (exp_row + 1) % BR;
      end
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [NL*DW-1:0] o;
    logic [NL*DW-1:0] c;
    logic [NL*RW-1:0] held;
    tests = 0; failures = 0; cyc = 0; exp_row = 0; exp_sad = 0;
    first_acc = -1; first_out = -1; lasts_seen = 0; last_sad_seen = -1; tag = 0;
    reset = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_residual", out_residual, 0);
    check("rst_out_sad", out_sad, 0);
    check("rst_in_ready", in_ready, 1'b1);
    reset = 1'b1;

    // Full-rate block of +150 residuals; latency and single last beat.
    for (int i = 0; i < BR; i++) cycle(1'b1, {NL{8'd200}}, {NL{8'd50}}, 1'b1, 1'b0);
    drain(3);
    check("latency", first_out - first_acc, 2);
    check("lane_150", out_residual[RW-1:0], 9'h096);
    check("one_last_per_block", lasts_seen, 1);

    // Extreme lane values: -255 and +255.
    o = {4{8'd255, 8'd0}};
    c = {4{8'd0, 8'd255}};
    cycle(1'b1, o, c, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    check("lane_neg255", out_residual[RW-1:0], 9'h101);
    check("lane_pos255", out_residual[2*RW-1:RW], 9'h0FF);
    drain(2);

    // Stall for 5 cycles mid-stream with sequence tags in lane 0.
    for (int i = 0; i < 14; i++) begin
      o = {$urandom, $urandom};
      o[DW-1:0] = DW'(tag);
      c = {$urandom, $urandom};
      c[DW-1:0] = '0;
      if (i == 4) held = out_residual;
      cycle(1'b1, o, c, !(i >= 3 && i < 8), 1'b0);
      if (i == 6) begin
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_hold", out_residual, held);
      end
      if (last_acc) tag++;
    end
    drain(3);

    // Flush a partial block, then a fresh block must end on its 8th beat.
    for (int i = 0; i < 3; i++) cycle(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
    cycle(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b1);
    check("flush_clears", out_valid, 1'b0);
    lasts_seen = 0;
    for (int i = 0; i < BR; i++) cycle(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
    drain(3);
    check("flush_block_last", lasts_seen, 1);

    // Async reset while output is valid; next block counts from row 0.
    for (int i = 0; i < 3; i++) cycle(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
    check("pre_reset_valid", out_valid, 1'b1);
    #1 reset = 1'b0;
    #1;
    check("async_reset_valid", out_valid, 1'b0);
    check("async_reset_residual", out_residual, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    q.delete();
    exp_row = 0;
    exp_sad = 0;
    lasts_seen = 0;
    for (int i = 0; i < BR; i++) cycle(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
    drain(3);
    check("post_reset_last", lasts_seen, 1);

    // Block SAD: diff 10 then diff 1, no carry-over.
    for (int i = 0; i < BR; i++) cycle(1'b1, {NL{8'd60}}, {NL{8'd50}}, 1'b1, 1'b0);
    drain(3);
`ifdef RESIDUAL_SAD_EN
    check("sad_640", last_sad_seen, 640);
`else
    check("sad_off_0", last_sad_seen, 0);
`endif
    for (int i = 0; i < BR; i++) cycle(1'b1, {NL{8'd50}}, {NL{8'd51}}, 1'b1, 1'b0);
    drain(3);
`ifdef RESIDUAL_SAD_EN
    check("sad_64", last_sad_seen, 64);
`else
    check("sad_off_0b", last_sad_seen, 0);
`endif

    // Randomized traffic with backpressure and occasional flush.
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    end
    drain(4);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
